// File: rtl/riscv_apu_resp.sv
// APU responder: accepts granted operations, computes them with a fixed-latency unit,
// and returns results in order through a two-slot queue (head/tail).
module riscv_apu_resp #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WADDR_WIDTH = 6,
  parameter int unsigned LAT_MULTI   = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      apu_slave_req_i,
  output logic                      apu_slave_gnt_o,
  input  logic [2:0]                apu_slave_op_i,
  input  logic [1:0]                apu_slave_lat_i,
  input  logic [3*DATA_WIDTH-1:0]   apu_slave_operands_i,
  input  logic [WADDR_WIDTH-1:0]    apu_slave_waddr_i,
  output logic                      apu_slave_valid_o,
  input  logic                      apu_slave_ready_i,
  output logic [DATA_WIDTH-1:0]     apu_slave_result_o,
  output logic [WADDR_WIDTH-1:0]    apu_slave_waddr_o,
  output logic                      apu_slave_err_o
);

  localparam int unsigned CNT_WIDTH = 4;

  typedef struct packed {
    logic                   vld;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [WADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0]  result;
    logic                   err;
  } slot_t;

  slot_t head_q, head_d;
  slot_t tail_q, tail_d;

  logic [DATA_WIDTH-1:0] op_a, op_b, op_c;
  logic [DATA_WIDTH-1:0] res_c;
  logic                  err_c;
  logic [CNT_WIDTH-1:0]  lat_m1_c;
  logic                  valid_c;
  logic                  pop_c;
  logic                  space_c;
  logic                  remain_c;
  logic [CNT_WIDTH-1:0]  young_cnt_c;
  logic                  order_ok_c;
  logic                  gnt_c;
  slot_t                 rem_head_c, rem_tail_c, new_slot_c;

  assign op_a = apu_slave_operands_i[DATA_WIDTH-1:0];
  assign op_b = apu_slave_operands_i[2*DATA_WIDTH-1:DATA_WIDTH];
  assign op_c = apu_slave_operands_i[3*DATA_WIDTH-1:2*DATA_WIDTH];

  // Arithmetic unit: result is captured at acceptance, operands are not kept.
  always_comb begin
    res_c = '0;
    err_c = 1'b0;
    case (apu_slave_op_i)
      3'd0: res_c = op_a + op_b;
      3'd1: res_c = op_a - op_b;
      3'd2: res_c = op_a * op_b;
      3'd3: res_c = op_a * op_b + op_c;
      3'd4: res_c = ($signed(op_a) < $signed(op_b)) ? op_a : op_b;
      3'd5: res_c = ($signed(op_a) < $signed(op_b)) ? op_b : op_a;
      default: begin
        res_c = '0;
        err_c = 1'b1;
      end
    endcase
  end

  always_comb begin
    lat_m1_c = '0;
    case (apu_slave_lat_i)
      2'h2:    lat_m1_c = CNT_WIDTH'(1);
      2'h3:    lat_m1_c = CNT_WIDTH'(LAT_MULTI - 1);
      default: lat_m1_c = '0;
    endcase
  end

  function automatic slot_t dec_slot(input slot_t s);
    slot_t r;
    r = s;
    if (s.vld && (s.cnt != '0)) r.cnt = s.cnt - CNT_WIDTH'(1);
    return r;
  endfunction

  assign valid_c = head_q.vld && (head_q.cnt == '0);
  assign pop_c   = valid_c && apu_slave_ready_i;

  // Queue contents after this cycle's countdown and pop, before any accept.
  always_comb begin
    rem_head_c = dec_slot(head_q);
    rem_tail_c = dec_slot(tail_q);
    if (pop_c) begin
      rem_head_c = dec_slot(tail_q);
      rem_tail_c = '0;
    end
  end

  // Ordering check uses the youngest surviving entry's current count.
  always_comb begin
    young_cnt_c = '0;
    if (pop_c) begin
      remain_c    = tail_q.vld;
      young_cnt_c = tail_q.cnt;
    end else begin
      remain_c = head_q.vld;
      if (tail_q.vld)      young_cnt_c = tail_q.cnt;
      else if (head_q.vld) young_cnt_c = head_q.cnt;
    end
  end

  assign space_c    = !tail_q.vld || pop_c;
  assign order_ok_c = !remain_c || (lat_m1_c >= young_cnt_c);
  assign gnt_c      = apu_slave_req_i && !rst_i && space_c && order_ok_c;

  always_comb begin
    new_slot_c        = '0;
    new_slot_c.vld    = 1'b1;
    new_slot_c.cnt    = lat_m1_c;
    new_slot_c.waddr  = apu_slave_waddr_i;
    new_slot_c.result = res_c;
    new_slot_c.err    = err_c;
  end

  always_comb begin
    head_d = rem_head_c;
    tail_d = rem_tail_c;
    if (gnt_c) begin
      if (!rem_head_c.vld) head_d = new_slot_c;
      else                 tail_d = new_slot_c;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign apu_slave_gnt_o    = gnt_c;
  assign apu_slave_valid_o  = valid_c;
  assign apu_slave_result_o = head_q.vld ? head_q.result : '0;
  assign apu_slave_waddr_o  = head_q.vld ? head_q.waddr  : '0;
  assign apu_slave_err_o    = head_q.vld ? head_q.err    : 1'b0;

endmodule
